raster_timing_gen: RTL and testbench



---
 rtl/raster_pkg.sv | 38 +++
 rtl/sync_delay_line.sv | 38 +++
 rtl/raster_timing_gen.sv | 147 ++++++++++++++
 tb/tb_raster_timing_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared raster timing constants: default SVGA 800x600@60 (40 MHz pixel
// rate) timing, the derived totals and sync windows for that default, and
// the coordinate widths used by the overlay comparators.
package raster_pkg;

    // Coordinate widths on the gr_x/gr_y interface.
    localparam int GR_X_W = 11;
    localparam int GR_Y_W = 10;

    // Default horizontal timing in pixels.
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;

    // Default vertical timing in lines.
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    // Default sync polarities, where 1 means the pulse is high.
    localparam bit DEF_HS_POL = 1'b1;
    localparam bit DEF_VS_POL = 1'b1;

    // Default alignment delay for the *_d outputs, and its supported maximum.
    localparam int DEF_PIPE_DLY = 1;
    localparam int PIPE_DLY_MAX = 7;

    // Derived totals and sync windows for the default timing.
    localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
    localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

endpackage

// File: rtl/sync_delay_line.sv
// Clock-enable qualified shift register used to delay sync and active-video
// flags so they line up with downstream registered overlay outputs.
// DEPTH must be at least 1; a zero-depth delay is handled by the caller as a
// plain wire. Reset loads every stage with the INACTIVE pattern, so the
// delayed outputs show idle levels until real data has shifted through.
module sync_delay_line
    import raster_pkg::*;
#(
    parameter int               DEPTH    = 1,
    parameter int               WIDTH    = 3,
    parameter logic [WIDTH-1:0] INACTIVE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr_p1 [DEPTH];

    // Shift one stage per enabled pixel step; stage 0 takes the new sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_p1[i] <= INACTIVE;
            end
        end else if (ce) begin
            sr_p1[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr_p1[i] <= sr_p1[i-1];
            end
        end
    end

    assign q = sr_p1[DEPTH-1];

endmodule

// File: rtl/raster_timing_gen.sv
// Raster scan timing generator. Internal counters (h_p0, v_p0) hold the
// position that the next pixel step presents. On each enabled step that
// position, together with its decoded sync, active-video and line/frame
// strobes, is registered onto the outputs, and the counters advance.
// hsync_d/vsync_d/enable_d are the same flags delayed by PIPE_DLY pixel
// steps (0..7) so they line up with the overlays' registered outputs.
module raster_timing_gen
    import raster_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL,
    parameter int PIPE_DLY = DEF_PIPE_DLY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_ce,
    output logic [GR_X_W-1:0] gr_x,
    output logic [GR_Y_W-1:0] gr_y,
    output logic              enable,
    output logic              hsync,
    output logic              vsync,
    output logic              line_start,
    output logic              frame_start,
    output logic              hsync_d,
    output logic              vsync_d,
    output logic              enable_d
);

    // Timing boundaries at counter width so every compare is unsigned and
    // width-matched.
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [GR_X_W-1:0] H_LAST_C   = GR_X_W'(H_TOT - 1);
    localparam logic [GR_X_W-1:0] H_ACT_C    = GR_X_W'(H_ACTIVE);
    localparam logic [GR_X_W-1:0] HS_FIRST_C = GR_X_W'(H_ACTIVE + H_FP);
    localparam logic [GR_X_W-1:0] HS_LAST_C  = GR_X_W'(H_ACTIVE + H_FP + H_SYNC - 1);

    localparam logic [GR_Y_W-1:0] V_LAST_C   = GR_Y_W'(V_TOT - 1);
    localparam logic [GR_Y_W-1:0] V_ACT_C    = GR_Y_W'(V_ACTIVE);
    localparam logic [GR_Y_W-1:0] VS_FIRST_C = GR_Y_W'(V_ACTIVE + V_FP);
    localparam logic [GR_Y_W-1:0] VS_LAST_C  = GR_Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic HS_OFF = ~HS_POL;
    localparam logic VS_OFF = ~VS_POL;

    // Stage p0: next-position counters and their decode.
    logic [GR_X_W-1:0] h_p0;
    logic [GR_Y_W-1:0] v_p0;
    logic              h_last_p0;
    logic              v_last_p0;
    logic              enable_p0;
    logic              hsync_p0;
    logic              vsync_p0;
    logic              line_p0;
    logic              frame_p0;

    // Advance the next-position counters one pixel per enabled step,
    // wrapping at the end of each line and at the end of the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_p0 <= '0;
            v_p0 <= '0;
        end else if (pix_ce) begin
            if (h_last_p0) begin
                h_p0 <= '0;
                v_p0 <= v_last_p0 ? '0 : v_p0 + GR_Y_W'(1);
            end else begin
                h_p0 <= h_p0 + GR_X_W'(1);
            end
        end
    end

    // Decode the position about to be presented. vsync depends only on the
    // line number, so once registered it changes only when gr_x returns to 0.
    always_comb begin
        h_last_p0 = (h_p0 == H_LAST_C);
        v_last_p0 = (v_p0 == V_LAST_C);
        enable_p0 = (h_p0 < H_ACT_C) && (v_p0 < V_ACT_C);
        hsync_p0  = ((h_p0 >= HS_FIRST_C) && (h_p0 <= HS_LAST_C)) ? HS_POL : HS_OFF;
        vsync_p0  = ((v_p0 >= VS_FIRST_C) && (v_p0 <= VS_LAST_C)) ? VS_POL : VS_OFF;
        line_p0   = (h_p0 == '0);
        frame_p0  = line_p0 && (v_p0 == '0);
    end

    // Stage p1: present the position and its flags. Strobes clear on any
    // idle step so each one is a single clk cycle wide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gr_x        <= '0;
            gr_y        <= '0;
            enable      <= 1'b0;
            hsync       <= HS_OFF;
            vsync       <= VS_OFF;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            gr_x        <= h_p0;
            gr_y        <= v_p0;
            enable      <= enable_p0;
            hsync       <= hsync_p0;
            vsync       <= vsync_p0;
            line_start  <= line_p0;
            frame_start <= frame_p0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

    // Stage p2: alignment delay on {hsync, vsync, enable}.
    logic [2:0] sync_p1;
    logic [2:0] sync_d;

    assign sync_p1 = {hsync, vsync, enable};

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign sync_d = sync_p1;
        end else begin : g_dly
            localparam logic [2:0] SYNC_IDLE = {HS_OFF, VS_OFF, 1'b0};

            sync_delay_line #(
                .DEPTH   (PIPE_DLY),
                .WIDTH   (3),
                .INACTIVE(SYNC_IDLE)
            ) u_sync_dly (
                .clk  (clk),
                .reset(reset),
                .ce   (pix_ce),
                .d    (sync_p1),
                .q    (sync_d)
            );
        end
    endgenerate

    assign {hsync_d, vsync_d, enable_d} = sync_d;

endmodule

// File: tb/tb_raster_timing_gen.sv
// Testbench for raster_timing_gen. Three instances share clk/reset/pix_ce:
// default SVGA timing with PIPE_DLY=1, default timing with PIPE_DLY=3, and a
// tiny 17x10 raster (inverted hsync polarity, PIPE_DLY=0) so that whole
// frames fit in a short run. The reference model counts pixel steps since
// reset and derives position and flags arithmetically from that count.
module tb_raster_timing_gen;

    typedef struct packed {
        int ha; int hf; int hsw; int hb;
        int va; int vf; int vsw; int vb;
        bit hp; bit vp; int dly;
    } tim_t;

    localparam tim_t TA = '{ha:800, hf:40, hsw:128, hb:88, va:600, vf:1, vsw:4, vb:23,
                            hp:1'b1, vp:1'b1, dly:1};
    localparam tim_t TB = '{ha:800, hf:40, hsw:128, hb:88, va:600, vf:1, vsw:4, vb:23,
                            hp:1'b1, vp:1'b1, dly:3};
    localparam tim_t TC = '{ha:10, hf:2, hsw:3, hb:2, va:6, vf:1, vsw:2, vb:1,
                            hp:1'b0, vp:1'b1, dly:0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_ce = 1'b0;

    logic [10:0] a_gx, b_gx, c_gx;
    logic [9:0]  a_gy, b_gy, c_gy;
    logic a_en, a_hs, a_vs, a_ls, a_fs, a_hsd, a_vsd, a_end;
    logic b_en, b_hs, b_vs, b_ls, b_fs, b_hsd, b_vsd, b_end;
    logic c_en, c_hs, c_vs, c_ls, c_fs, c_hsd, c_vsd, c_end;

    int  vectors;
    int  miscompares;
    int  n;          // pixel steps taken since reset released
    bit  strobe;     // the most recent clk edge was a pixel step
    int  last_fs_n;

    always #5 clk = ~clk;

    raster_timing_gen u_a (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .gr_x(a_gx), .gr_y(a_gy), .enable(a_en), .hsync(a_hs), .vsync(a_vs),
        .line_start(a_ls), .frame_start(a_fs),
        .hsync_d(a_hsd), .vsync_d(a_vsd), .enable_d(a_end)
    );

    raster_timing_gen #(.PIPE_DLY(3)) u_b (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .gr_x(b_gx), .gr_y(b_gy), .enable(b_en), .hsync(b_hs), .vsync(b_vs),
        .line_start(b_ls), .frame_start(b_fs),
        .hsync_d(b_hsd), .vsync_d(b_vsd), .enable_d(b_end)
    );

    raster_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_DLY(0)
    ) u_c (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .gr_x(c_gx), .gr_y(c_gy), .enable(c_en), .hsync(c_hs), .vsync(c_vs),
        .line_start(c_ls), .frame_start(c_fs),
        .hsync_d(c_hsd), .vsync_d(c_vsd), .enable_d(c_end)
    );

    // Position presented after pixel step k (k=0 means nothing presented yet).
    function automatic int pos_x(input tim_t t, input int k);
        if (k <= 0) return 0;
        return (k - 1) % (t.ha + t.hf + t.hsw + t.hb);
    endfunction

    function automatic int pos_y(input tim_t t, input int k);
        if (k <= 0) return 0;
        return ((k - 1) / (t.ha + t.hf + t.hsw + t.hb)) % (t.va + t.vf + t.vsw + t.vb);
    endfunction

    // {hsync, vsync, enable} presented after pixel step k; idle levels for k<=0.
    function automatic logic [2:0] sig_at(input tim_t t, input int k);
        int x, y;
        logic h, v, e;
        if (k <= 0) return {~t.hp, ~t.vp, 1'b0};
        x = pos_x(t, k);
        y = pos_y(t, k);
        h = (x >= t.ha + t.hf && x < t.ha + t.hf + t.hsw) ? t.hp : ~t.hp;
        v = (y >= t.va + t.vf && y < t.va + t.vf + t.vsw) ? t.vp : ~t.vp;
        e = (x < t.ha) && (y < t.va);
        return {h, v, e};
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input string nm, input tim_t t,
                              input logic [10:0] gx, input logic [9:0] gy,
                              input logic en, input logic hs, input logic vs,
                              input logic ls, input logic fs,
                              input logic hsd, input logic vsd, input logic ed);
        int x, y;
        logic [2:0] s, sd;
        logic ls_e, fs_e;
        x = pos_x(t, n);
        y = pos_y(t, n);
        s = sig_at(t, n);
        sd = sig_at(t, n - t.dly);
        ls_e = strobe && (x == 0);
        fs_e = ls_e && (y == 0);
        cmp({nm, ".gr_x"}, 32'(gx), 32'(x));
        cmp({nm, ".gr_y"}, 32'(gy), 32'(y));
        cmp({nm, ".hsync"}, 32'(hs), 32'(s[2]));
        cmp({nm, ".vsync"}, 32'(vs), 32'(s[1]));
        cmp({nm, ".enable"}, 32'(en), 32'(s[0]));
        cmp({nm, ".line_start"}, 32'(ls), 32'(ls_e));
        cmp({nm, ".frame_start"}, 32'(fs), 32'(fs_e));
        cmp({nm, ".hsync_d"}, 32'(hsd), 32'(sd[2]));
        cmp({nm, ".vsync_d"}, 32'(vsd), 32'(sd[1]));
        cmp({nm, ".enable_d"}, 32'(ed), 32'(sd[0]));
    endtask

    task automatic check_all();
        check_inst("a", TA, a_gx, a_gy, a_en, a_hs, a_vs, a_ls, a_fs, a_hsd, a_vsd, a_end);
        check_inst("b", TB, b_gx, b_gy, b_en, b_hs, b_vs, b_ls, b_fs, b_hsd, b_vsd, b_end);
        check_inst("c", TC, c_gx, c_gy, c_en, c_hs, c_vs, c_ls, c_fs, c_hsd, c_vsd, c_end);
    endtask

    // One clk cycle: drive on the falling edge, update the model at the
    // rising edge, sample 1 time unit later.
    task automatic tick(input logic rst_v, input logic ce);
        @(negedge clk);
        reset  = rst_v;
        pix_ce = ce;
        @(posedge clk);
        if (!rst_v && ce) begin
            n++;
            strobe = 1'b1;
        end else begin
            strobe = 1'b0;
            if (rst_v) begin
                n = 0;
                last_fs_n = -1;
            end
        end
        #1;
        check_all();
        if (c_fs === 1'b1) begin
            if (last_fs_n >= 0) cmp("c.frame_period", 32'(n - last_fs_n), 32'd170);
            last_fs_n = n;
        end
    endtask

    // Assert reset between clock edges and check outputs without an edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n = 0;
        strobe = 1'b0;
        last_fs_n = -1;
        check_all();
        cmp("c.reset_hsync_level", 32'(c_hs), 32'd1);
        cmp("a.reset_gr_x", 32'(a_gx), 32'd0);
    endtask

    initial begin
        int hs_cnt, max_x, a_fall_x, b_fall_x, a_rise_x, b_rise_x;
        logic pa_end, pb_end, pa_hsd, pb_hsd;
        logic [10:0] held_x;
        logic ce;

        vectors = 0;
        miscompares = 0;
        n = 0;
        strobe = 1'b0;
        last_fs_n = -1;

        // Reset held with pix_ce active: nothing advances.
        repeat (3) tick(1'b1, 1'b1);

        // Release coincides with the first advance.
        tick(1'b0, 1'b1);
        cmp("a.first_gr_x", 32'(a_gx), 32'd0);
        cmp("a.first_enable", 32'(a_en), 32'd1);
        cmp("a.first_frame_start", 32'(a_fs), 32'd1);
        cmp("a.first_line_start", 32'(a_ls), 32'd1);
        tick(1'b0, 1'b1);
        cmp("a.second_gr_x", 32'(a_gx), 32'd1);
        cmp("a.second_line_start", 32'(a_ls), 32'd0);
        cmp("a.second_frame_start", 32'(a_fs), 32'd0);

        // One full default line plus a few pixels of the next.
        hs_cnt = 0; max_x = 0;
        a_fall_x = -1; b_fall_x = -1; a_rise_x = -1; b_rise_x = -1;
        pa_end = a_end; pb_end = b_end; pa_hsd = a_hsd; pb_hsd = b_hsd;
        for (int i = 0; i < 1060; i++) begin
            tick(1'b0, 1'b1);
            if (a_hs === 1'b1) hs_cnt++;
            if (int'(a_gx) > max_x) max_x = int'(a_gx);
            if (pa_end && !a_end && a_fall_x < 0) a_fall_x = int'(a_gx);
            if (pb_end && !b_end && b_fall_x < 0) b_fall_x = int'(b_gx);
            if (!pa_hsd && a_hsd && a_rise_x < 0) a_rise_x = int'(a_gx);
            if (!pb_hsd && b_hsd && b_rise_x < 0) b_rise_x = int'(b_gx);
            pa_end = a_end; pb_end = b_end; pa_hsd = a_hsd; pb_hsd = b_hsd;
        end
        cmp("a.hsync_width", 32'(hs_cnt), 32'd128);
        cmp("a.max_gr_x", 32'(max_x), 32'd1055);
        cmp("a.enable_d_fall_x", 32'(a_fall_x), 32'd801);
        cmp("b.enable_d_fall_x", 32'(b_fall_x), 32'd803);
        cmp("a.hsync_d_rise_x", 32'(a_rise_x), 32'd841);
        cmp("b.hsync_d_rise_x", 32'(b_rise_x), 32'd843);
        cmp("a.next_line_gr_y", 32'(a_gy), 32'd1);

        // pix_ce alternating 1,0: outputs hold on idle cycles.
        for (int i = 0; i < 40; i++) begin
            held_x = c_gx;
            ce = ((i % 2) == 0);
            tick(1'b0, ce);
            if (!ce) cmp("c.hold_gr_x", 32'(c_gx), 32'(held_x));
        end

        // Random pixel-enable pattern over several small frames.
        for (int i = 0; i < 800; i++) begin
            tick(1'b0, $urandom_range(0, 3) != 0);
        end

        // Reset mid-frame, hold it briefly, then restart from (0,0).
        async_reset();
        repeat (2) tick(1'b1, $urandom_range(0, 1) != 0);
        tick(1'b0, 1'b1);
        cmp("c.restart_gr_x", 32'(c_gx), 32'd0);
        cmp("c.restart_gr_y", 32'(c_gy), 32'd0);
        cmp("c.restart_frame_start", 32'(c_fs), 32'd1);

        for (int i = 0; i < 400; i++) begin
            tick(1'b0, $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
